// File: rtl/shift_out_driver.sv
// Parallel-to-serial driver for a 74HC595-style chain.
// Shifts a captured word out MSB-first, then pulses the storage latch.
module shift_out_driver #(
   parameter int DIGITS  = 6,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DIGITS-1:0] data_in,
   input  logic              load,
   output logic              busy,
   output logic              done,
   output logic              ser_data,
   output logic              ser_clk,
   output logic              ser_latch
);

   localparam int BW = $clog2(DIGITS) + 1;
   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(DIGITS - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT_LO,
      SHIFT_HI,
      LATCH
   } state_t;

   state_t            state;
   logic [DIGITS-1:0] shreg;
   logic [BW-1:0]     bit_cnt;
   logic [DW-1:0]     div_cnt;
   logic              div_end;

   assign div_end = (div_cnt == DIV_LAST);

   // shreg holds only the bits not yet presented on ser_data
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ser_data  <= 1'b0;
         ser_clk   <= 1'b0;
         ser_latch <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (load) begin
                  shreg    <= data_in << 1;
                  ser_data <= data_in[DIGITS-1];
                  bit_cnt  <= '0;
                  div_cnt  <= '0;
                  busy     <= 1'b1;
                  ser_clk  <= 1'b0;
                  state    <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (div_end) begin
                  div_cnt <= '0;
                  ser_clk <= 1'b1;
                  state   <= SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt + DIV_ONE;
               end
            end
            SHIFT_HI: begin
               if (div_end) begin
                  div_cnt <= '0;
                  ser_clk <= 1'b0;
                  if (bit_cnt == BIT_LAST) begin
                     ser_data  <= 1'b0;
                     ser_latch <= 1'b1;
                     state     <= LATCH;
                  end else begin
                     ser_data <= shreg[DIGITS-1];
                     shreg    <= shreg << 1;
                     bit_cnt  <= bit_cnt + BIT_ONE;
                     state    <= SHIFT_LO;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_ONE;
               end
            end
            LATCH: begin
               if (div_end) begin
                  div_cnt   <= '0;
                  ser_latch <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end else begin
                  div_cnt <= div_cnt + DIV_ONE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_out_driver.sv
// Bench for shift_out_driver: default and minimal (1-bit, div 1) instances
// checked every cycle against a transfer-offset waveform model.
module tb_shift_out_driver;

   localparam int DG  = 6;
   localparam int CD  = 4;
   localparam int T   = 2 * CD * DG + CD;
   localparam int DG1 = 1;
   localparam int CD1 = 1;
   localparam int T1  = 2 * CD1 * DG1 + CD1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b0;
   logic          load  = 1'b0;
   logic          load1 = 1'b0;
   logic [DG-1:0] data_in  = '0;
   logic [0:0]    data_in1 = '0;
   logic busy, done, sd, sc, sl;
   logic busy1, done1, sd1, sc1, sl1;

   shift_out_driver #(.DIGITS(DG), .CLK_DIV(CD)) u_a (
      .clk(clk), .reset(reset), .data_in(data_in), .load(load),
      .busy(busy), .done(done), .ser_data(sd), .ser_clk(sc),
      .ser_latch(sl)
   );

   shift_out_driver #(.DIGITS(DG1), .CLK_DIV(CD1)) u_b (
      .clk(clk), .reset(reset), .data_in(data_in1), .load(load1),
      .busy(busy1), .done(done1), .ser_data(sd1), .ser_clk(sc1),
      .ser_latch(sl1)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // model: t = cycles since transfer start (-1 = idle)
   int ta = -1, tb = -1;
   int wa = 0, wb = 0;
   bit da = 1'b0, db = 1'b0;

   logic prev_sc = 1'b0;
   bit   rise_bits[$];
   int   dones, busy_cyc, busy_lo, latch_cyc, busy1_cyc;

   // {busy, done, ser_clk, ser_data, ser_latch}
   function automatic logic [4:0] expect_out(int t, int w, int cd,
                                             int dg, bit dn);
      logic c, d;
      if (t < 0) return {1'b0, dn, 3'b000};
      if (t < 2 * cd * dg) begin
         c = ((t / cd) % 2) == 1;
         d = ((w >> (dg - 1 - t / (2 * cd))) & 1) == 1;
         return {1'b1, 1'b0, c, d, 1'b0};
      end
      return 5'b10001;
   endfunction

   task automatic advance(inout int t, inout int w, inout bit dn,
                          input bit rs, input bit ld, input int din,
                          input int tt);
      bit nd;
      nd = rs && (t == tt - 1);
      if (!rs) t = -1;
      else if (t >= 0) begin
         t++;
         if (t == tt) t = -1;
      end else if (ld) begin
         t = 0;
         w = din;
      end
      dn = nd;
   endtask

   task automatic chk(string tag, int obs, int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(string tag, logic [4:0] obs, logic [4:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      rise_bits.delete();
      dones = 0; busy_cyc = 0; busy_lo = 0; latch_cyc = 0; busy1_cyc = 0;
   endtask

   task automatic step();
      @(posedge clk);
      advance(ta, wa, da, reset, load, int'(data_in), T);
      advance(tb, wb, db, reset, load1, int'(data_in1), T1);
      #1;
      chk_vec("out_a", {busy, done, sc, sd, sl},
              expect_out(ta, wa, CD, DG, da));
      chk_vec("out_b", {busy1, done1, sc1, sd1, sl1},
              expect_out(tb, wb, CD1, DG1, db));
      if (sc === 1'b1 && prev_sc === 1'b0) rise_bits.push_back(sd);
      prev_sc = sc;
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busy_cyc++;
      else busy_lo++;
      if (sl === 1'b1) latch_cyc++;
      if (busy1 === 1'b1) busy1_cyc++;
   endtask

   function automatic int rise_word();
      int v = 0;
      foreach (rise_bits[i]) v = (v << 1) | int'(rise_bits[i]);
      return v;
   endfunction

   initial begin
      // reset held with load asserted
      reset = 1'b0; load = 1'b1; load1 = 1'b1;
      data_in = 6'b111111; data_in1 = 1'b1;
      repeat (3) step();
      reset = 1'b1; load = 1'b0; load1 = 1'b0;
      clear_stats();
      repeat (5) step();
      chk("idle_after_reset", busy_cyc, 0);

      // single transfer
      clear_stats();
      data_in = 6'b101100; load = 1'b1;
      step();
      load = 1'b0; data_in = '0;
      repeat (T + 5) step();
      chk("t2_bits", rise_word(), 6'b101100);
      chk("t2_rises", rise_bits.size(), DG);
      chk("t2_busy", busy_cyc, T);
      chk("t2_latch", latch_cyc, CD);
      chk("t2_done", dones, 1);

      // load during transfer is ignored
      clear_stats();
      data_in = 6'b110010; load = 1'b1;
      step();
      load = 1'b0;
      repeat (9) step();
      data_in = 6'b111111; load = 1'b1;
      step();
      load = 1'b0;
      repeat (T) step();
      chk("t3_bits", rise_word(), 6'b110010);
      chk("t3_done", dones, 1);

      // load held through done: one idle cycle between transfers
      clear_stats();
      load = 1'b1;
      for (int i = 0; i < 2 * T + 1; i++) begin
         data_in = DG'($urandom);
         step();
      end
      load = 1'b0;
      chk("t4_gap", busy_lo, 1);
      chk("t4_done", dones, 1);
      repeat (4) step();
      chk("t4_done2", dones, 2);

      // reset during SHIFT_HI of bit 3
      clear_stats();
      data_in = 6'b011011; load = 1'b1;
      step();
      load = 1'b0;
      repeat (29) step();
      chk("t5_in_hi", int'(sc), 1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("t5_abort", int'({busy, sc, sd, sl}), 0);
      repeat (T + 5) step();
      chk("t5_no_done", dones, 0);
      clear_stats();
      data_in = DG'($urandom); load = 1'b1;
      step();
      load = 1'b0;
      repeat (T + 2) step();
      chk("t5_recover", dones, 1);

      // minimal instance: 1 bit, divider 1
      clear_stats();
      data_in1 = 1'b1; load1 = 1'b1;
      step();
      load1 = 1'b0;
      chk("t6_lo", int'({busy1, sc1, sd1, sl1}), 4'b1010);
      step();
      chk("t6_hi", int'({busy1, sc1, sd1, sl1}), 4'b1110);
      step();
      chk("t6_latch", int'({busy1, sc1, sd1, sl1}), 4'b1001);
      step();
      chk("t6_done", int'(done1), 1);
      chk("t6_busy", busy1_cyc, 3);

      // random traffic on both instances
      for (int i = 0; i < 600; i++) begin
         load     = ($urandom_range(0, 7) == 0);
         load1    = ($urandom_range(0, 1) == 0);
         data_in  = DG'($urandom);
         data_in1 = 1'($urandom);
         reset    = ($urandom_range(0, 149) != 0);
         step();
      end
      reset = 1'b1; load = 1'b0; load1 = 1'b0;
      repeat (T + 2) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
